// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port, byte-writable, 1-cycle-latency RAM between ibus (read) and dbus (read/write).
// Define RAM_ARBITER_RR_EN for round-robin arbitration; when it is undefined, dbus has fixed priority.
module ram_arbiter #(
    parameter int DEPTH         = 16384,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_req,
    input  logic [ADDRESS_WIDTH-1:2] i_addr,
    output logic                     i_ack,
    output logic [31:0]              i_rdata,
    input  logic                     d_req,
    input  logic [ADDRESS_WIDTH-1:2] d_addr,
    input  logic [3:0]               d_we,
    input  logic [31:0]              d_wdata,
    output logic                     d_ack,
    output logic [31:0]              d_rdata,
    output logic [ADDRESS_WIDTH-1:2] ram_addr,
    output logic [3:0]               ram_we,
    output logic [31:0]              ram_data,
    input  logic [31:0]              ram_q
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;
    typedef enum logic {BUS_I = 1'b0, BUS_D = 1'b1} bus_t;

    state_t                   state_q, state_d;
    bus_t                     owner_q, owner_d;
    bus_t                     grant;
    logic [ADDRESS_WIDTH-1:2] ram_addr_q, ram_addr_d;
    logic [3:0]               ram_we_q, ram_we_d;
    logic [31:0]              ram_data_q, ram_data_d;
    logic                     i_ack_q, i_ack_d;
    logic                     d_ack_q, d_ack_d;
    logic [31:0]              i_rdata_q, i_rdata_d;
    logic [31:0]              d_rdata_q, d_rdata_d;

`ifdef RAM_ARBITER_RR_EN
    bus_t last_grant_q, last_grant_d;

    // On a tie, the bus that did not win last time goes first.
    always_comb begin
        if (i_req && d_req) begin
            grant = (last_grant_q == BUS_I) ? BUS_D : BUS_I;
        end else if (d_req) begin
            grant = BUS_D;
        end else begin
            grant = BUS_I;
        end
    end
`else
    always_comb begin
        grant = d_req ? BUS_D : BUS_I;
    end
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ram_addr_d = ram_addr_q;
        ram_we_d   = ram_we_q;
        ram_data_d = ram_data_q;
        i_ack_d    = 1'b0;
        d_ack_d    = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
`ifdef RAM_ARBITER_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    owner_d    = grant;
                    ram_addr_d = (grant == BUS_D) ? d_addr : i_addr;
                    ram_we_d   = (grant == BUS_D) ? d_we : 4'd0;
                    ram_data_d = (grant == BUS_D) ? d_wdata : 32'd0;
`ifdef RAM_ARBITER_RR_EN
                    last_grant_d = grant;
`endif
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                ram_we_d = 4'd0;
                i_ack_d  = (owner_q == BUS_I);
                d_ack_d  = (owner_q == BUS_D);
                state_d  = RESP;
            end
            RESP: begin
                if (i_ack_q) i_rdata_d = ram_q;
                if (d_ack_q) d_rdata_d = ram_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= BUS_I;
            ram_addr_q <= '0;
            ram_we_q   <= 4'd0;
            ram_data_q <= 32'd0;
            i_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            i_rdata_q  <= 32'd0;
            d_rdata_q  <= 32'd0;
`ifdef RAM_ARBITER_RR_EN
            last_grant_q <= BUS_I;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ram_addr_q <= ram_addr_d;
            ram_we_q   <= ram_we_d;
            ram_data_q <= ram_data_d;
            i_ack_q    <= i_ack_d;
            d_ack_q    <= d_ack_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
`ifdef RAM_ARBITER_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_we   = ram_we_q;
    assign ram_data = ram_data_q;
    assign i_ack    = i_ack_q;
    assign d_ack    = d_ack_q;

    // RAM data only arrives in the ack cycle, so it is passed straight through
    // then and held in a register afterwards.
    assign i_rdata = i_ack_q ? ram_q : i_rdata_q;
    assign d_rdata = d_ack_q ? ram_q : d_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed spec scenarios plus random traffic against a reference memory.
// Arbitration expectations follow RAM_ARBITER_RR_EN when it is defined.
module tb_ram_arbiter;
    localparam int DEPTH = 16384;
    localparam int AW    = $clog2(DEPTH);
    localparam int WA    = AW - 2;
`ifdef RAM_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req, i_ack, d_req, d_ack;
    logic [WA-1:0] i_addr, d_addr, ram_addr;
    logic [3:0]    d_we, ram_we;
    logic [31:0]   d_wdata, i_rdata, d_rdata, ram_data, ram_q;

    logic          bd_en;
    logic [WA-1:0] bd_addr;
    logic [31:0]   bd_data;

    logic [31:0] mem     [0:(1<<WA)-1];
    logic [31:0] ref_mem [0:(1<<WA)-1];

    int checks   = 0;
    int failures = 0;
    bit model_last;   // 0 = ibus, 1 = dbus

    ram_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_data(ram_data), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // Single-port RAM with registered read (old data on write) and a preload port.
    always @(posedge clk) begin
        ram_q <= mem[ram_addr];
        for (int b = 0; b < 4; b++)
            if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_data[8*b +: 8];
        if (bd_en) mem[bd_addr] <= bd_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic preload(input logic [WA-1:0] a, input logic [31:0] v);
        bd_en = 1'b1; bd_addr = a; bd_data = v;
        tick();
        bd_en = 1'b0;
        ref_mem[a] = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        model_last = 1'b0;
    endtask

    // One transaction round starting in an idle cycle (cycle 0); returns the acked read words.
    task automatic round(input bit use_i, input bit use_d, input logic [WA-1:0] ia,
                         input logic [WA-1:0] da, input logic [3:0] we, input logic [31:0] wd,
                         output logic [31:0] got_i, output logic [31:0] got_d);
        bit          i_first;
        int          ci, cd;
        logic [31:0] exp_i, exp_d;
        if (use_i && use_d) i_first = RR ? model_last : 1'b0;
        else                i_first = use_i;
        ci = -1; cd = -1; exp_i = '0; exp_d = '0; got_i = '0; got_d = '0;
        if (use_i && i_first) begin
            exp_i = ref_mem[ia]; ci = 2; model_last = 1'b0;
        end
        if (use_d) begin
            exp_d = ref_mem[da];
            ref_mem[da] = merge(exp_d, wd, we);
            cd = i_first ? 5 : 2;
            model_last = 1'b1;
        end
        if (use_i && !i_first) begin
            exp_i = ref_mem[ia]; ci = use_d ? 5 : 2; model_last = 1'b0;
        end
        i_req = use_i; i_addr = ia;
        d_req = use_d; d_addr = da; d_we = we; d_wdata = wd;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check("i_ack", {31'd0, i_ack}, {31'd0, c == ci});
            check("d_ack", {31'd0, d_ack}, {31'd0, c == cd});
            check("ram_we", {28'd0, ram_we}, {28'd0, (c == cd - 1) ? we : 4'd0});
            if (c == ci || c == ci + 1) check("i_rdata", i_rdata, exp_i);
            if (c == cd || c == cd + 1) check("d_rdata", d_rdata, exp_d);
            if (c == ci) begin got_i = i_rdata; i_req = 1'b0; end
            if (c == cd) begin got_d = d_rdata; d_req = 1'b0; end
        end
    endtask

    initial begin
        logic [31:0] gi, gd, rd1, rd2;
        bit          exp_ack, win_d;
        int          t1, t2;

        rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0;
        i_addr = '0; d_addr = '0; d_we = '0; d_wdata = '0;
        bd_en = 1'b0; bd_addr = '0; bd_data = '0;
        model_last = 1'b0;

        // Reset held three cycles with both requests pending.
        i_req = 1'b1; d_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_i_ack", {31'd0, i_ack}, 32'd0);
            check("rst_d_ack", {31'd0, d_ack}, 32'd0);
            check("rst_ram_we", {28'd0, ram_we}, 32'd0);
        end
        check("rst_ram_addr", {{(32-WA){1'b0}}, ram_addr}, 32'd0);
        check("rst_ram_data", ram_data, 32'd0);
        i_req = 1'b0; d_req = 1'b0;

        for (int a = 0; a < 32; a++) preload(WA'(a), $urandom);
        preload(WA'('h10), 32'hDEADBEEF);
        preload(WA'('h20), 32'h11223344);
        rst_n = 1'b1;
        tick();

        // ibus read of a preloaded word.
        round(1'b1, 1'b0, WA'('h10), '0, 4'd0, 32'd0, gi, gd);
        check("t2_i_rdata", gi, 32'hDEADBEEF);

        // dbus byte write returns the old word, then the merged word reads back.
        round(1'b0, 1'b1, '0, WA'('h20), 4'b0010, 32'hAABBCCDD, gi, gd);
        check("t3_d_rdata", gd, 32'h11223344);
        round(1'b1, 1'b0, WA'('h20), '0, 4'd0, 32'd0, gi, gd);
        check("t3_readback", gi, 32'h1122CC44);

        // Continuous contention for five accesses.
        do_reset();
        i_addr = WA'('h10); d_addr = WA'('h20); d_we = 4'd0; i_req = 1'b1; d_req = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            exp_ack = (c % 3 == 2);
            win_d = 1'b0;
            if (exp_ack) begin
                win_d = RR ? !model_last : 1'b1;
                model_last = win_d;
            end
            check("t4_i_ack", {31'd0, i_ack}, {31'd0, exp_ack && !win_d});
            check("t4_d_ack", {31'd0, d_ack}, {31'd0, exp_ack && win_d});
            if (exp_ack && win_d)  check("t4_d_rdata", d_rdata, ref_mem[WA'('h20)]);
            if (exp_ack && !win_d) check("t4_i_rdata", i_rdata, ref_mem[WA'('h10)]);
        end
        i_req = 1'b0; d_req = 1'b0;

        // Reset during the ISSUE cycle of a dbus write abandons it.
        d_req = 1'b1; d_addr = WA'(40); d_we = 4'hF; d_wdata = $urandom;
        tick();
        check("t5_issue_we", {28'd0, ram_we}, 32'hF);
        rst_n = 1'b0; d_req = 1'b0;
        tick();
        check("t5_d_ack", {31'd0, d_ack}, 32'd0);
        check("t5_i_ack", {31'd0, i_ack}, 32'd0);
        check("t5_ram_we", {28'd0, ram_we}, 32'd0);
        rst_n = 1'b1;
        model_last = 1'b0;
        tick();
        check("t5_quiet", {30'd0, i_ack, d_ack}, 32'd0);
        round(1'b1, 1'b1, WA'(3), WA'(7), 4'b1001, $urandom, gi, gd);

        // Back-to-back ibus reads: second ack exactly three cycles after the first.
        i_req = 1'b1; i_addr = WA'('h10);
        t1 = -1; t2 = -1; rd1 = '0; rd2 = '0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (i_ack) begin
                if (t1 < 0) begin
                    t1 = c; rd1 = i_rdata;
                end else if (t2 < 0) begin
                    t2 = c; rd2 = i_rdata; i_req = 1'b0;
                end
            end else if (t1 >= 0 && t2 < 0 && c == t1 + 1) begin
                i_addr = WA'('h20);
            end
        end
        i_req = 1'b0;
        model_last = 1'b0;
        check("t6_first_lat", t1, 32'd2);
        check("t6_gap", t2 - t1, 32'd3);
        check("t6_rdata1", rd1, ref_mem[WA'('h10)]);
        check("t6_rdata2", rd2, ref_mem[WA'('h20)]);

        // Random traffic against the reference memory.
        for (int r = 0; r < 40; r++) begin
            int sel;
            sel = int'($urandom_range(1, 3));
            round(sel[0], sel[1], WA'($urandom_range(0, 31)), WA'($urandom_range(0, 31)),
                  4'($urandom_range(0, 15)), $urandom, gi, gd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
